wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter. It is the next generation of the team's fixed 4-way round-robin arbiter, generalised to N requesters with a per-requester burst weight, registered one-hot grant, encoded grant index and an optional lock. It sits between N bus masters and a single shared slave port and decides which master owns the port each cycle.

---
 rtl/wrr_arbiter.sv | 146 ++++++++++++++
 tb/tb_wrr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters, per-master burst weight, registered one-hot grant.
// Define WRR_LOCK_EN to add a per-master lock input that extends the granted master's quantum.
`timescale 1ns/1ps
module wrr_arbiter #(
    parameter int unsigned  N  = 4,
    parameter int unsigned  WW = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
`ifdef WRR_LOCK_EN
    input  logic [N-1:0]    lock,
`endif
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_id,
    output logic            busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   cur_n;
    logic [WW-1:0]   credit;
    logic [WW-1:0]   credit_n;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_n;
    logic [N-1:0]    grant_n;
    logic [IW-1:0]   grant_id_n;
    logic            busy_n;

    logic [N-1:0]    eligible;
    logic [IW-1:0]   start;
    logic [IW-1:0]   sel;
    logic            found;
    logic            hold_lock;
    logic            rearb;

    // Modulo-N addition keeps indices inside 0..N-1 even when N is not a power of two.
    function automatic logic [IW-1:0] mod_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = req[i] && (weight[i*WW +: WW] != '0);
        end
    end

    // First eligible master at or after start, wrapping; on re-arbitration cur is checked last.
    always_comb begin
        start = (state == S_GRANT) ? mod_add(cur, 1) : ptr;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && eligible[mod_add(start, k)]) begin
                found = 1'b1;
                sel   = mod_add(start, k);
            end
        end
    end

`ifdef WRR_LOCK_EN
    assign hold_lock = lock[cur];
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        credit_n   = credit;
        ptr_n      = ptr;
        rearb      = 1'b0;
        grant_n    = '0;
        grant_id_n = '0;
        busy_n     = 1'b0;

        case (state)
            S_IDLE: begin
                rearb = 1'b1;
            end
            S_GRANT: begin
                if (!req[cur] || ((credit == WW'(1)) && !hold_lock)) begin
                    rearb = 1'b1;
                end else if (credit > WW'(1)) begin
                    credit_n = credit - WW'(1);
                end
            end
            default: begin
                rearb = 1'b1;
            end
        endcase

        // A new grant samples the winner's weight once; later weight changes are ignored.
        if (rearb) begin
            if (found) begin
                state_n  = S_GRANT;
                cur_n    = sel;
                credit_n = weight[32'(sel)*WW +: WW];
                ptr_n    = mod_add(sel, 1);
            end else begin
                state_n  = S_IDLE;
            end
        end

        if (state_n == S_GRANT) begin
            grant_n    = N'(1) << cur_n;
            grant_id_n = cur_n;
            busy_n     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cur      <= '0;
            credit   <= '0;
            ptr      <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            credit   <= credit_n;
            ptr      <= ptr_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (N=4 main instance, N=3 instance for modulo wrap).
`timescale 1ns/1ps
module tb_wrr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;
    logic [2:0]  req3;
    logic [11:0] weight3;
    logic [2:0]  grant3;
    logic [1:0]  grant_id3;
    logic        busy3;
`ifdef WRR_LOCK_EN
    logic [3:0]  lock;
    logic [2:0]  lock3;
`endif

    int pass_cnt;
    int total_cnt;

    wrr_arbiter #(.N(4), .WW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .weight   (weight),
`ifdef WRR_LOCK_EN
        .lock     (lock),
`endif
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy)
    );

    wrr_arbiter #(.N(3), .WW(4)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .req      (req3),
        .weight   (weight3),
`ifdef WRR_LOCK_EN
        .lock     (lock3),
`endif
        .grant    (grant3),
        .grant_id (grant_id3),
        .busy     (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        weight = 16'h1111;
        step();
        step();
        total_cnt++;
        if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant);
        else pass_cnt++;
        total_cnt++;
        if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_id;
        weight = 16'h1111;
        req = 4'b1111;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            exp_id = i % 4;
            total_cnt++;
            if (grant !== 4'(1 << exp_id)) $display("FAIL rr_grant cyc %0d: got %b expected %b", i, grant, 4'(1 << exp_id));
            else pass_cnt++;
            total_cnt++;
            if (grant_id !== 2'(exp_id)) $display("FAIL rr_grant_id cyc %0d: got %0d expected %0d", i, grant_id, exp_id);
            else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL rr_busy cyc %0d: got %b expected 1", i, busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_weighted();
        int seq [14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
        weight = 16'h1213;
        req = 4'b1111;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step();
            total_cnt++;
            if (grant !== 4'(1 << seq[i])) $display("FAIL wrr_grant cyc %0d: got %b expected %b", i, grant, 4'(1 << seq[i]));
            else pass_cnt++;
            total_cnt++;
            if (grant_id !== 2'(seq[i])) $display("FAIL wrr_grant_id cyc %0d: got %0d expected %0d", i, grant_id, seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_masked();
        weight = 16'h1021;
        req = 4'b0100;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            total_cnt++;
            if ({grant, busy} !== 5'b0) $display("FAIL masked_idle cyc %0d: got grant %b busy %b expected 0000 0", i, grant, busy);
            else pass_cnt++;
        end
        req = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if (grant !== 4'b0010) $display("FAIL masked_grant cyc %0d: got %b expected 0010", i, grant);
            else pass_cnt++;
            total_cnt++;
            if (grant_id !== 2'd1) $display("FAIL masked_grant_id cyc %0d: got %0d expected 1", i, grant_id);
            else pass_cnt++;
        end
    endtask

    task automatic test_early_drop();
        weight = 16'h1115;
        req = 4'b0001;
        do_reset();
        step();
        total_cnt++;
        if (grant !== 4'b0001) $display("FAIL drop_first: got %b expected 0001", grant);
        else pass_cnt++;
        step();
        req = 4'b1010;
        total_cnt++;
        if (grant !== 4'b0001) $display("FAIL drop_hold_one: got %b expected 0001", grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL drop_handover: got %b expected 0010", grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (grant !== 4'b1000) $display("FAIL drop_next: got %b expected 1000", grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL drop_wrap: got %b expected 0010", grant);
        else pass_cnt++;
        req = 4'b0000;
        step();
        total_cnt++;
        if ({grant, grant_id, busy} !== 7'b0) $display("FAIL drop_idle: got grant %b id %0d busy %b expected 0000 0 0", grant, grant_id, busy);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        weight = 16'h1111;
        req = 4'b0011;
        do_reset();
        step();
        total_cnt++;
        if (grant !== 4'b0001) $display("FAIL simul_first: got %b expected 0001", grant);
        else pass_cnt++;
        req = 4'b0010;
        step();
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL simul_rearb: got %b expected 0010", grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL simul_sole_regrant: got %b expected 0010", grant);
        else pass_cnt++;
        req = 4'b1010;
        step();
        total_cnt++;
        if (grant !== 4'b1000) $display("FAIL simul_new_req: got %b expected 1000", grant);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        weight = 16'h1311;
        req = 4'b1111;
        do_reset();
        step();
        step();
        step();
        total_cnt++;
        if (grant !== 4'b0100) $display("FAIL areset_pre: got %b expected 0100", grant);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #0.5;
        total_cnt++;
        if ({grant, grant_id, busy} !== 7'b0) $display("FAIL areset_clear: got grant %b id %0d busy %b expected 0000 0 0", grant, grant_id, busy);
        else pass_cnt++;
        #0.5;
        rst = 1'b0;
        step();
        total_cnt++;
        if (grant !== 4'b0001) $display("FAIL areset_first: got %b expected 0001", grant);
        else pass_cnt++;
        total_cnt++;
        if (grant_id !== 2'd0) $display("FAIL areset_first_id: got %0d expected 0", grant_id);
        else pass_cnt++;
    endtask

    task automatic test_wrap_n3();
        int exp_id;
        weight3 = 12'h111;
        req3 = 3'b111;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            exp_id = i % 3;
            total_cnt++;
            if (grant3 !== 3'(1 << exp_id)) $display("FAIL n3_grant cyc %0d: got %b expected %b", i, grant3, 3'(1 << exp_id));
            else pass_cnt++;
            total_cnt++;
            if (grant_id3 !== 2'(exp_id)) $display("FAIL n3_grant_id cyc %0d: got %0d expected %0d", i, grant_id3, exp_id);
            else pass_cnt++;
        end
        req3 = 3'b000;
    endtask

`ifdef WRR_LOCK_EN
    task automatic test_lock();
        weight = 16'h1121;
        lock = 4'b0010;
        req = 4'b1111;
        do_reset();
        step();
        total_cnt++;
        if (grant !== 4'b0001) $display("FAIL lock_first: got %b expected 0001", grant);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            step();
            total_cnt++;
            if (grant !== 4'b0010) $display("FAIL lock_hold cyc %0d: got %b expected 0010", i, grant);
            else pass_cnt++;
        end
        lock = 4'b0000;
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL lock_release_hold: got %b expected 0010", grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (grant !== 4'b0100) $display("FAIL lock_release_next: got %b expected 0100", grant);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        req = 4'b0000;
        weight = 16'h0000;
        req3 = 3'b000;
        weight3 = 12'h000;
`ifdef WRR_LOCK_EN
        lock = 4'b0000;
        lock3 = 3'b000;
`endif
        test_reset();
        test_round_robin();
        test_weighted();
        test_masked();
        test_early_drop();
        test_simultaneous();
        test_async_reset();
        test_wrap_n3();
`ifdef WRR_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
